// File: rtl/pix_assembler_if.sv
// Byte-in / pixel-out bus of the UART-to-pixel assembler.
// master drives received bytes and the enable; slave (the assembler) returns pixels and status.
interface pix_assembler_if #(
   parameter int PIX_W = 12,
   parameter int CNT_W = 17
);
   logic [7:0]       i_rx_data;
   logic             i_rx_done;
   logic             i_enable;
   logic [1:0]       o_state;
   logic [PIX_W-1:0] o_pix;
   logic             o_pix_valid;
   logic [CNT_W-1:0] o_pix_addr;
   logic [7:0]       o_check_code;
   logic             o_frame_done;
   logic             o_timeout_err;

   modport master (
      output i_rx_data, i_rx_done, i_enable,
      input  o_state, o_pix, o_pix_valid, o_pix_addr, o_check_code, o_frame_done, o_timeout_err
   );

   modport slave (
      input  i_rx_data, i_rx_done, i_enable,
      output o_state, o_pix, o_pix_valid, o_pix_addr, o_check_code, o_frame_done, o_timeout_err
   );
endinterface

// File: rtl/pix_assembler.sv
// Packs BYTES_PER_PIX UART bytes (MSB-first) into pixels with frame address, check code and EOF pulse.
// Optional inter-byte timeout compiled in with `define PIX_ASM_TIMEOUT_EN.
module pix_assembler #(
   parameter int BYTES_PER_PIX = 2,
   parameter int PIX_W         = 12,
   parameter int FRAME_PIX     = 76800,
   parameter int CNT_W         = 17,
   parameter int TIMEOUT_CYC   = 50000
) (
   input  logic            i_clk_sys,
   input  logic            i_rst_n,
   pix_assembler_if.slave  bus
);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_COLLECT = 2'b01;
   localparam logic [1:0] ST_DONE    = 2'b10;

   localparam int IDX_W = 2;
   localparam int CAT_W = 8 * BYTES_PER_PIX;
   // Only the leading bytes need storage; the final byte is used straight off the bus.
   localparam int BUF_N = (BYTES_PER_PIX > 1) ? BYTES_PER_PIX - 1 : 1;

   generate
      if (BYTES_PER_PIX < 1 || BYTES_PER_PIX > 4) begin : g_bad_bpp
         $error("pix_assembler: BYTES_PER_PIX must be 1..4");
      end
      if (PIX_W < 1 || PIX_W > CAT_W) begin : g_bad_pixw
         $error("pix_assembler: PIX_W must be 1..8*BYTES_PER_PIX");
      end
      if (FRAME_PIX < 1 || (64'(1) << CNT_W) < 64'(FRAME_PIX)) begin : g_bad_frame
         $error("pix_assembler: FRAME_PIX must be >= 1 and fit in CNT_W bits");
      end
      if (TIMEOUT_CYC < 2) begin : g_bad_timeout
         $error("pix_assembler: TIMEOUT_CYC must be >= 2");
      end
   endgenerate

   logic [1:0]       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       buf_reg [BUF_N];

   logic [PIX_W-1:0] pix_reg, pix_next;
   logic [CNT_W-1:0] addr_reg, addr_next;
   logic [7:0]       code_reg, code_next;
   logic             valid_reg, valid_next;
   logic             fdone_reg, fdone_next;
   logic             err_reg, err_next;

   logic [CAT_W-1:0] cat;
   logic [7:0]       first_byte;
   logic             accept;
   logic             last_byte;
   logic             frame_end;
   logic             expire;

   assign accept     = bus.i_enable && bus.i_rx_done && (state_reg != ST_DONE);
   assign last_byte  = (idx_reg == IDX_W'(BYTES_PER_PIX - 1));
   assign frame_end  = (cnt_reg == CNT_W'(FRAME_PIX - 1));
   assign first_byte = cat[CAT_W-1 -: 8];

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_PIX; gi++) begin : g_cat
         if (gi == BYTES_PER_PIX - 1) begin : g_live
            assign cat[8*(BYTES_PER_PIX-1-gi) +: 8] = bus.i_rx_data;
         end else begin : g_stored
            assign cat[8*(BYTES_PER_PIX-1-gi) +: 8] = buf_reg[gi];
         end
      end

      for (gi = 0; gi < BYTES_PER_PIX - 1; gi++) begin : g_buf
         always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
            if (!i_rst_n) begin
               buf_reg[gi] <= '0;
            end else if (accept && idx_reg == IDX_W'(gi)) begin
               buf_reg[gi] <= bus.i_rx_data;
            end
         end
      end
   endgenerate

`ifdef PIX_ASM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC);

   logic [TO_W-1:0] to_reg, to_next;

   // Expiry is flagged on the cycle whose edge would bring the idle count to TIMEOUT_CYC;
   // a byte arriving in that cycle wins and restarts the count.
   always_comb begin
      to_next = '0;
      expire  = 1'b0;
      if (bus.i_enable && state_reg == ST_COLLECT && idx_reg != '0 && !bus.i_rx_done) begin
         if (to_reg == TO_W'(TIMEOUT_CYC - 1)) begin
            expire = 1'b1;
         end else begin
            to_next = to_reg + TO_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_reg <= '0;
      end else begin
         to_reg <= to_next;
      end
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      pix_next   = pix_reg;
      addr_next  = addr_reg;
      code_next  = code_reg;
      valid_next = 1'b0;
      fdone_next = 1'b0;
      err_next   = 1'b0;

      if (!bus.i_enable) begin
         // Disabling drops any partial pixel silently and restarts the frame.
         state_next = ST_IDLE;
         idx_next   = '0;
         cnt_next   = '0;
      end else if (state_reg == ST_DONE) begin
         state_next = ST_DONE;
      end else begin
         state_next = ST_COLLECT;
         if (accept) begin
            if (last_byte) begin
               idx_next   = '0;
               pix_next   = PIX_W'(cat >> (CAT_W - PIX_W));
               addr_next  = cnt_reg;
               code_next  = {first_byte[7], first_byte[4], first_byte[3], first_byte[0],
                             bus.i_rx_data[7], bus.i_rx_data[4], bus.i_rx_data[3], bus.i_rx_data[0]};
               valid_next = 1'b1;
               cnt_next   = cnt_reg + CNT_W'(1);
               if (frame_end) begin
                  fdone_next = 1'b1;
                  state_next = ST_DONE;
               end
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end else if (expire) begin
            idx_next = '0;
            err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         pix_reg   <= '0;
         addr_reg  <= '0;
         code_reg  <= '0;
         valid_reg <= 1'b0;
         fdone_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         pix_reg   <= pix_next;
         addr_reg  <= addr_next;
         code_reg  <= code_next;
         valid_reg <= valid_next;
         fdone_reg <= fdone_next;
         err_reg   <= err_next;
      end
   end

   assign bus.o_state       = state_reg;
   assign bus.o_pix         = pix_reg;
   assign bus.o_pix_valid   = valid_reg;
   assign bus.o_pix_addr    = addr_reg;
   assign bus.o_check_code  = code_reg;
   assign bus.o_frame_done  = fdone_reg;
   assign bus.o_timeout_err = err_reg;

endmodule

// File: tb/tb_pix_assembler.sv
// Directed bench for pix_assembler: a 2-byte/12-bit DUT with a 4-pixel frame and a 3-byte/18-bit DUT.
// Timeout expectations follow whether PIX_ASM_TIMEOUT_EN is defined for the build.
module tb_pix_assembler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pix_assembler_if #(.PIX_W(12), .CNT_W(17)) ifa ();
   pix_assembler_if #(.PIX_W(18), .CNT_W(3))  ifb ();

   pix_assembler #(
      .BYTES_PER_PIX(2), .PIX_W(12), .FRAME_PIX(4), .CNT_W(17), .TIMEOUT_CYC(16)
   ) dut_a (
      .i_clk_sys(clk), .i_rst_n(rst_n), .bus(ifa)
   );

   pix_assembler #(
      .BYTES_PER_PIX(3), .PIX_W(18), .FRAME_PIX(8), .CNT_W(3), .TIMEOUT_CYC(16)
   ) dut_b (
      .i_clk_sys(clk), .i_rst_n(rst_n), .bus(ifb)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   int          a_valid_cnt = 0;
   int          a_fd_cnt    = 0;
   int          a_fd_stray  = 0;
   int          a_err_cnt   = 0;
   logic [31:0] a_pix       = '0;
   logic [31:0] a_addr      = '0;
   logic [31:0] a_code      = '0;
   int          a_addr_q[$];
   int          b_valid_cnt = 0;
   logic [31:0] b_pix       = '0;
   logic [31:0] b_code      = '0;

   // Outputs are captured on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (ifa.o_pix_valid) begin
         a_valid_cnt++;
         a_pix  = 32'(ifa.o_pix);
         a_addr = 32'(ifa.o_pix_addr);
         a_code = 32'(ifa.o_check_code);
         a_addr_q.push_back(int'(ifa.o_pix_addr));
         if (ifa.o_frame_done) a_fd_cnt++;
      end else if (ifa.o_frame_done) begin
         a_fd_stray++;
      end
      if (ifa.o_timeout_err) a_err_cnt++;
      if (ifb.o_pix_valid) begin
         b_valid_cnt++;
         b_pix  = 32'(ifb.o_pix);
         b_code = 32'(ifb.o_check_code);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic byte_a(input logic [7:0] b);
      ifa.i_rx_data = b;
      ifa.i_rx_done = 1'b1;
      tick(1);
      ifa.i_rx_done = 1'b0;
   endtask

   task automatic byte_b(input logic [7:0] b);
      ifb.i_rx_data = b;
      ifb.i_rx_done = 1'b1;
      tick(1);
      ifb.i_rx_done = 1'b0;
   endtask

   task automatic reenable_a();
      ifa.i_enable = 1'b0;
      tick(1);
      ifa.i_enable = 1'b1;
      tick(1);
   endtask

   int v0, e0, f0;

   initial begin
      ifa.i_rx_data = '0; ifa.i_rx_done = 1'b0; ifa.i_enable = 1'b0;
      ifb.i_rx_data = '0; ifb.i_rx_done = 1'b0; ifb.i_enable = 1'b0;
      rst_n = 1'b0;
      tick(3);

      check_eq("rst_state",  32'(ifa.o_state), 32'h0);
      check_eq("rst_pix",    32'(ifa.o_pix), 32'h0);
      check_eq("rst_addr",   32'(ifa.o_pix_addr), 32'h0);
      check_eq("rst_code",   32'(ifa.o_check_code), 32'h0);
      check_eq("rst_valid",  32'(ifa.o_pix_valid), 32'h0);
      check_eq("rst_b_pix",  32'(ifb.o_pix), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Basic two-byte pixel.
      ifa.i_enable = 1'b1;
      tick(1);
      v0 = a_valid_cnt;
      byte_a(8'hA5);
      byte_a(8'h3C);
      tick(3);
      check_eq("basic_valid_n", 32'(a_valid_cnt - v0), 32'd1);
      check_eq("basic_pix",     a_pix, 32'hA53);
      check_eq("basic_code",    a_code, 32'h96);
      check_eq("basic_addr",    a_addr, 32'h0);
      check_eq("basic_state",   32'(ifa.o_state), 32'h1);

      // Lone byte followed by a long gap.
      reenable_a();
      v0 = a_valid_cnt;
      e0 = a_err_cnt;
      byte_a(8'h12);
      tick(25);
`ifdef PIX_ASM_TIMEOUT_EN
      check_eq("tmo_err_n", 32'(a_err_cnt - e0), 32'd1);
`else
      check_eq("tmo_err_n", 32'(a_err_cnt - e0), 32'd0);
`endif
      byte_a(8'hAB);
      byte_a(8'hCD);
      tick(2);
      check_eq("tmo_valid_n", 32'(a_valid_cnt - v0), 32'd1);
`ifdef PIX_ASM_TIMEOUT_EN
      check_eq("tmo_pix", a_pix, 32'hABC);
`else
      check_eq("tmo_pix", a_pix, 32'h12A);
`endif
      check_eq("tmo_addr", a_addr, 32'h0);

      // Ten back-to-back bytes against a 4-pixel frame.
      reenable_a();
      v0 = a_valid_cnt;
      f0 = a_fd_cnt;
      a_addr_q.delete();
      for (int i = 1; i <= 10; i++) byte_a(8'(i));
      tick(2);
      check_eq("frm_valid_n", 32'(a_valid_cnt - v0), 32'd4);
      check_eq("frm_addr_qn", 32'(a_addr_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < a_addr_q.size()) check_eq($sformatf("frm_addr%0d", i), 32'(a_addr_q[i]), 32'(i));
      end
      check_eq("frm_done_n",  32'(a_fd_cnt - f0), 32'd1);
      check_eq("frm_stray",   32'(a_fd_stray), 32'd0);
      check_eq("frm_state",   32'(ifa.o_state), 32'h2);
      check_eq("frm_pix",     a_pix, 32'h070);
      check_eq("frm_code",    a_code, 32'h12);
      ifa.i_enable = 1'b0;
      tick(1);
      check_eq("frm_idle",    32'(ifa.o_state), 32'h0);
      ifa.i_enable = 1'b1;
      tick(1);
      byte_a(8'h44);
      byte_a(8'h55);
      tick(2);
      check_eq("frm2_pix",    a_pix, 32'h445);
      check_eq("frm2_addr",   a_addr, 32'h0);

      // Enable dropped for one cycle mid-pixel.
      reenable_a();
      e0 = a_err_cnt;
      byte_a(8'h11);
      ifa.i_enable = 1'b0;
      tick(1);
      ifa.i_enable = 1'b1;
      byte_a(8'h22);
      byte_a(8'h33);
      tick(2);
      check_eq("drop_pix",   a_pix, 32'h223);
      check_eq("drop_addr",  a_addr, 32'h0);
      check_eq("drop_err_n", 32'(a_err_cnt - e0), 32'd0);

      // Three-byte, 18-bit pixel.
      ifb.i_enable = 1'b1;
      tick(1);
      v0 = b_valid_cnt;
      byte_b(8'hFF);
      byte_b(8'h00);
      byte_b(8'hC3);
      tick(2);
      check_eq("b3_valid_n", 32'(b_valid_cnt - v0), 32'd1);
      check_eq("b3_pix",     b_pix, 32'h3FC03);
      check_eq("b3_code",    b_code, 32'hF9);

      // Asynchronous reset after the first byte of a pixel.
      reenable_a();
      byte_a(8'h77);
      rst_n = 1'b0;
      #2;
      check_eq("arst_state", 32'(ifa.o_state), 32'h0);
      check_eq("arst_pix",   32'(ifa.o_pix), 32'h0);
      check_eq("arst_addr",  32'(ifa.o_pix_addr), 32'h0);
      check_eq("arst_code",  32'(ifa.o_check_code), 32'h0);
      check_eq("arst_valid", 32'(ifa.o_pix_valid), 32'h0);
      check_eq("arst_fd",    32'(ifa.o_frame_done), 32'h0);
      check_eq("arst_err",   32'(ifa.o_timeout_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      v0 = a_valid_cnt;
      byte_a(8'h5A);
      byte_a(8'h0F);
      tick(2);
      check_eq("arst2_valid_n", 32'(a_valid_cnt - v0), 32'd1);
      check_eq("arst2_pix",     a_pix, 32'h5A0);
      check_eq("arst2_addr",    a_addr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
